// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 read interface: pointer write, then reads of STATUS and angle
// registers, with a 12-bit snapshot that keeps the high and low angle bytes coherent.
module as5600_i2c_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h36,
  parameter logic [7:0] PTR_RESET = 8'h0C
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [11:0] raw_angle,
  input  logic        magnet_ok,
  output logic        busy,
  output logic        xfer_done,
  output logic [7:0]  reg_ptr,
  output logic        nack_seen
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StWrAck, StWdata, StRdata, StMack, StIgnore
  } state_e;

  state_e      state_q, state_d;
  logic        scl_s1, scl_s2, scl_dly, sda_s1, sda_s2, sda_dly;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        sda_low_q, sda_low_d;
  logic        busy_q, busy_d;
  logic        xfer_done_q, xfer_done_d;
  logic [7:0]  reg_ptr_q, reg_ptr_d;
  logic        nack_q, nack_d;
  logic [11:0] snap_q, snap_d, snap_src;
  logic [7:0]  rd_byte, rx_byte;
  logic        scl_rise, scl_fall, start_cond, stop_cond, load_tx;

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;
  assign reg_ptr   = reg_ptr_q;
  assign nack_seen = nack_q;

  assign scl_rise   = scl_s2 & ~scl_dly;
  assign scl_fall   = ~scl_s2 & scl_dly;
  assign start_cond = ~sda_s2 & sda_dly & scl_s2;
  assign stop_cond  = sda_s2 & ~sda_dly & scl_s2;
  assign rx_byte    = {shreg_q, sda_s2};

  // Angle-high pointers take a fresh sample; the matching low byte reuses the held snapshot.
  always_comb begin
    snap_src = snap_q;
    if (reg_ptr_q == 8'h0C || reg_ptr_q == 8'h0E) snap_src = raw_angle;
    case (reg_ptr_q)
      8'h0B:        rd_byte = {2'b00, magnet_ok, 5'b00000};
      8'h0C, 8'h0E: rd_byte = {4'h0, snap_src[11:8]};
      8'h0D, 8'h0F: rd_byte = snap_src[7:0];
      default:      rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    xfer_done_d = 1'b0;
    reg_ptr_d   = reg_ptr_q;
    nack_d      = nack_q;
    snap_d      = snap_q;
    load_tx     = 1'b0;

    if (start_cond) begin
      state_d   = StAddr;
      cnt_d     = 4'd0;
      nack_d    = 1'b0;
      sda_low_d = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_cond) begin
      state_d     = StIdle;
      sda_low_d   = 1'b0;
      phase_d     = 1'b0;
      busy_d      = 1'b0;
      xfer_done_d = busy_q;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              phase_d = 1'b0;
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StPtr) begin
                reg_ptr_d = rx_byte;
                state_d   = StWrAck;
              end else begin
                reg_ptr_d = reg_ptr_q + 8'd1;
                state_d   = StWrAck;
              end
            end
          end
        end
        // phase 0: next fall starts the ACK; phase 1: next fall ends it
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d   = 1'b1;
              sda_low_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              sda_low_d = 1'b0;
              if (state_q == StWrAck) state_d = StWdata;
              else if (!rw_q)         state_d = StPtr;
              else                    load_tx = 1'b1;
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              cnt_d     = 4'd0;
              phase_d   = 1'b0;
              state_d   = StMack;
            end else begin
              sda_low_d = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              cnt_d     = cnt_q + 4'd1;
            end
          end
        end
        StMack: begin
          if (!phase_q && scl_rise) begin
            reg_ptr_d = reg_ptr_q + 8'd1;
            if (sda_s2) begin
              nack_d  = 1'b1;
              state_d = StIgnore;
            end else begin
              phase_d = 1'b1;
            end
          end else if (phase_q && scl_fall) begin
            phase_d = 1'b0;
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_tx) begin
      snap_d    = snap_src;
      sda_low_d = ~rd_byte[7];
      tx_d      = {rd_byte[6:0], 1'b0};
      cnt_d     = 4'd1;
      state_d   = StRdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scl_s1      <= 1'b1;
      scl_s2      <= 1'b1;
      scl_dly     <= 1'b1;
      sda_s1      <= 1'b1;
      sda_s2      <= 1'b1;
      sda_dly     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      shreg_q     <= 7'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
      reg_ptr_q   <= PTR_RESET;
      nack_q      <= 1'b0;
      snap_q      <= 12'd0;
    end else begin
      scl_s1      <= scl;
      scl_s2      <= scl_s1;
      scl_dly     <= scl_s2;
      sda_s1      <= sda;
      sda_s2      <= sda_s1;
      sda_dly     <= sda_s2;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      xfer_done_q <= xfer_done_d;
      reg_ptr_q   <= reg_ptr_d;
      nack_q      <= nack_d;
      snap_q      <= snap_d;
    end
  end

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Directed bench for as5600_i2c_target: a bit-banged I2C initiator drives a table of register
// reads plus hand-written sequences for snapshot coherence, wrong address, writes and reset.
module tb_as5600_i2c_target;

  localparam int unsigned H = 20;
  localparam int unsigned Q = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        scl;
  logic        m_sda_low;
  wire         sda_line;
  logic [11:0] raw_angle;
  logic        magnet_ok;
  logic        busy, xfer_done, nack_seen;
  logic [7:0]  reg_ptr;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [7:0]  rd [4];

  assign sda_line = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  always #5 clock = ~clock;

  always @(posedge clock) if (xfer_done) done_cnt <= done_cnt + 1;

  as5600_i2c_target #(
    .DEV_ADDR (7'h36),
    .PTR_RESET(8'h0C)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda_line),
    .raw_angle(raw_angle),
    .magnet_ok(magnet_ok),
    .busy     (busy),
    .xfer_done(xfer_done),
    .reg_ptr  (reg_ptr),
    .nack_seen(nack_seen)
  );

  typedef struct {
    logic [7:0]       ptr;
    int               n;
    logic [11:0]      angle;
    logic             mag;
    logic [2:0][7:0]  exp_b;
    logic [7:0]       exp_ptr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(H);
    scl = 1'b1;       wait_clk(H);
    m_sda_low = 1'b1; wait_clk(H);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(H);
    scl = 1'b1;       wait_clk(H);
    m_sda_low = 1'b0; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; wait_clk(H);
    scl = 1'b1;     wait_clk(H);
    scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(H);
    scl = 1'b1;       wait_clk(H / 2);
    b = sda_line;     wait_clk(H / 2);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic last, output logic [7:0] b);
    logic bt;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(bt);
      b = {b[6:0], bt};
    end
    write_bit(last);
  endtask

  // Optional pointer write, repeated start, then an n-byte read NACKed on the last byte.
  task automatic do_xfer(input logic [7:0] ptr, input int n, input logic set_ptr,
                         input logic change_mid, input logic [11:0] new_angle);
    logic a;
    i2c_start();
    check("nack_cleared_by_start", {31'd0, nack_seen}, 32'd0);
    if (set_ptr) begin
      write_byte(8'h6C, a);
      check("ack_addr_wr", {31'd0, a}, 32'd0);
      check("busy_after_addr", {31'd0, busy}, 32'd1);
      write_byte(ptr, a);
      check("ack_ptr", {31'd0, a}, 32'd0);
      i2c_start();
    end
    write_byte(8'h6D, a);
    check("ack_addr_rd", {31'd0, a}, 32'd0);
    check("busy_in_read", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, rd[i]);
      if (change_mid && i == 0) raw_angle = new_angle;
    end
    i2c_stop();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  d0;
    logic a;
    logic [3:0] bits;
    logic bt;

    vecs[0] = '{8'h0C, 2, 12'hA5B, 1'b0, {8'h00, 8'h5B, 8'h0A}, 8'h0E};
    vecs[1] = '{8'h0B, 3, 12'h3C7, 1'b1, {8'hC7, 8'h03, 8'h20}, 8'h0E};
    vecs[2] = '{8'hFF, 2, 12'h123, 1'b1, {8'h00, 8'h00, 8'h00}, 8'h01};
    vecs[3] = '{8'h0E, 2, 12'h7FF, 1'b0, {8'h00, 8'hFF, 8'h07}, 8'h10};
    vecs[4] = '{8'h0B, 1, 12'hFFF, 1'b0, {8'h00, 8'h00, 8'h00}, 8'h0C};

    reset_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; raw_angle = 12'h000; magnet_ok = 1'b0;
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(5);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
    check("rst_nack", {31'd0, nack_seen}, 32'd0);
    check("rst_ptr", {24'd0, reg_ptr}, 32'h0C);
    check("rst_sda", {31'd0, sda_line}, 32'd1);

    // Read straight from the reset pointer
    raw_angle = 12'hA5B;
    d0 = done_cnt;
    do_xfer(8'h00, 2, 1'b0, 1'b0, 12'h000);
    check("ptrrst_b0", {24'd0, rd[0]}, 32'h0A);
    check("ptrrst_b1", {24'd0, rd[1]}, 32'h5B);
    check("ptrrst_ptr", {24'd0, reg_ptr}, 32'h0E);
    check("ptrrst_done", d0 + 1, done_cnt);

    for (int v = 0; v < 5; v++) begin
      raw_angle = vecs[v].angle;
      magnet_ok = vecs[v].mag;
      d0 = done_cnt;
      do_xfer(vecs[v].ptr, vecs[v].n, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < vecs[v].n; i++)
        check($sformatf("vec%0d_byte%0d", v, i), {24'd0, rd[i]}, {24'd0, vecs[v].exp_b[i]});
      check($sformatf("vec%0d_ptr", v), {24'd0, reg_ptr}, {24'd0, vecs[v].exp_ptr});
      check($sformatf("vec%0d_nack", v), {31'd0, nack_seen}, 32'd1);
      check($sformatf("vec%0d_done", v), d0 + 1, done_cnt);
      check($sformatf("vec%0d_busy_end", v), {31'd0, busy}, 32'd0);
    end

    // Angle changes between high and low byte; the held snapshot must be returned
    raw_angle = 12'hA5B;
    do_xfer(8'h0C, 2, 1'b1, 1'b1, 12'h123);
    check("snap_hi", {24'd0, rd[0]}, 32'h0A);
    check("snap_lo", {24'd0, rd[1]}, 32'h5B);
    do_xfer(8'h0C, 2, 1'b1, 1'b0, 12'h000);
    check("fresh_hi", {24'd0, rd[0]}, 32'h01);
    check("fresh_lo", {24'd0, rd[1]}, 32'h23);

    // Foreign address: no ACK, no busy, no xfer_done
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h70, a);
    check("wrong_addr_nak", {31'd0, a}, 32'd1);
    check("wrong_addr_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h0C, a);
    check("wrong_addr_data_nak", {31'd0, a}, 32'd1);
    i2c_stop();
    check("wrong_addr_no_done", d0, done_cnt);
    raw_angle = 12'h3C7;
    do_xfer(8'h0C, 2, 1'b1, 1'b0, 12'h000);
    check("after_wrong_hi", {24'd0, rd[0]}, 32'h03);
    check("after_wrong_lo", {24'd0, rd[1]}, 32'hC7);

    // Data write after the pointer is discarded but advances the pointer
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h6C, a);
    write_byte(8'h0A, a);
    write_byte(8'h55, a);
    check("wdata_ack", {31'd0, a}, 32'd0);
    i2c_stop();
    check("wdata_ptr", {24'd0, reg_ptr}, 32'h0B);
    check("wdata_done", d0 + 1, done_cnt);

    // Reset while the target is driving bit 3 of a 0x00 STATUS byte
    magnet_ok = 1'b0;
    i2c_start();
    write_byte(8'h6C, a);
    write_byte(8'h0B, a);
    i2c_start();
    write_byte(8'h6D, a);
    bits = 4'hF;
    for (int i = 0; i < 4; i++) begin
      read_bit(bt);
      bits = {bits[2:0], bt};
    end
    check("status_bits_7_4", {28'd0, bits}, 32'd0);
    check("rdata_bit3_driven", {31'd0, sda_line}, 32'd0);
    reset_n = 1'b0;
    wait_clk(1);
    check("midrst_sda", {31'd0, sda_line}, 32'd1);
    check("midrst_ptr", {24'd0, reg_ptr}, 32'h0C);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_clk(H);
    raw_angle = 12'h7FF;
    do_xfer(8'h00, 2, 1'b0, 1'b0, 12'h000);
    check("postrst_hi", {24'd0, rd[0]}, 32'h07);
    check("postrst_lo", {24'd0, rd[1]}, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
